// File: rtl/riscv_core_ahb_pkg.sv
// Shared AHB definitions for the L1 bus-matrix input stage: transfer and
// response encodings, local error-response FSM states and the address/control bundle.
package riscv_core_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int AHB_ADDR_W = 32;
  localparam int AHB_MST_W  = 4;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'b00,
    ERR_ONE  = 2'b01,
    ERR_TWO  = 2'b10
  } err_state_t;

  typedef struct packed {
    logic                  sel;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_ADDR_W-1:0] auser;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic [AHB_MST_W-1:0]  master;
    logic                  mastlock;
  } ahb_ctrl_t;

  // NONSEQ and SEQ both carry bit 1; IDLE and BUSY never request a slot
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/riscv_core_ahb_input_stage_if.sv
// Master-side AHB signals plus the output-stage facing request/response
// signals of one bus-matrix input stage.
interface riscv_core_ahb_input_stage_if #(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4
);
  logic              HSELS;
  logic [ADDR_W-1:0] HADDRS;
  logic [ADDR_W-1:0] HAUSERS;
  logic [1:0]        HTRANSS;
  logic              HWRITES;
  logic [2:0]        HSIZES;
  logic [2:0]        HBURSTS;
  logic [3:0]        HPROTS;
  logic [MST_W-1:0]  HMASTERS;
  logic              HMASTLOCKS;
  logic              HREADYS;
  logic              HREADYOUTS;
  logic              HRESPS;
  logic              sel_ip;
  logic [ADDR_W-1:0] addr_ip;
  logic [ADDR_W-1:0] auser_ip;
  logic [1:0]        trans_ip;
  logic              write_ip;
  logic [2:0]        size_ip;
  logic [2:0]        burst_ip;
  logic [3:0]        prot_ip;
  logic [MST_W-1:0]  master_ip;
  logic              mastlock_ip;
  logic              held_tran_ip;
  logic              active_ip;
  logic              readyout_ip;
  logic              resp_ip;
  logic              unmapped_ip;

  modport slave (
    input  HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTERS, HMASTLOCKS, HREADYS, active_ip, readyout_ip, resp_ip, unmapped_ip,
    output HREADYOUTS, HRESPS, sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip,
           burst_ip, prot_ip, master_ip, mastlock_ip, held_tran_ip
  );

  modport master (
    output HSELS, HADDRS, HAUSERS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTERS, HMASTLOCKS, HREADYS, active_ip, readyout_ip, resp_ip, unmapped_ip,
    input  HREADYOUTS, HRESPS, sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip,
           burst_ip, prot_ip, master_ip, mastlock_ip, held_tran_ip
  );

endinterface

// File: rtl/riscv_core_ahb_hold_reg.sv
// Capture register for one pending address phase and the held/live select
// that feeds the output stages.
module riscv_core_ahb_hold_reg
  import riscv_core_ahb_pkg::*;
#(
  parameter type ctrl_t = ahb_ctrl_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  capture,
  input  logic  hold,
  input  ctrl_t live,
  output ctrl_t muxed
);

  ctrl_t held_r;

  // latch the address phase that could not be forwarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r <= '0;
    end else if (capture) begin
      held_r <= live;
    end else begin
      held_r <= held_r;
    end
  end

  // held copy wins while a transfer is pending
  always_comb begin
    muxed = live;
    if (hold) begin
      muxed = held_r;
    end else begin
      muxed = live;
    end
  end

endmodule

// File: rtl/riscv_core_ahb_input_stage.sv
// AHB bus-matrix input stage: holds a master's address phase until granted and
// drives wait states/responses back. Define RISCV_CORE_AHB_UNMAPPED_ERR_EN for local error responses.
module riscv_core_ahb_input_stage
  import riscv_core_ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MST_W  = 4
) (
  input logic                         HCLK,
  input logic                         HRESETn,
  riscv_core_ahb_input_stage_if.slave bus
);

  typedef struct packed {
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] auser;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic [MST_W-1:0]  master;
    logic              mastlock;
  } ctrl_t;

  ctrl_t live_s;
  ctrl_t muxed_s;
  logic  trans_req_s;
  logic  unmapped_req_s;
  logic  fwd_req_s;
  logic  capture_s;
  logic  release_s;
  logic  accept_s;
  logic  err_busy_s;
  logic  err_ready_s;
  logic  hreadyout_s;
  logic  hresp_s;
  logic  reg_hold_r;
  logic  dphase_r;

  assign live_s = '{sel: bus.HSELS, addr: bus.HADDRS, auser: bus.HAUSERS, trans: bus.HTRANSS,
                    write: bus.HWRITES, size: bus.HSIZES, burst: bus.HBURSTS, prot: bus.HPROTS,
                    master: bus.HMASTERS, mastlock: bus.HMASTLOCKS};

  assign trans_req_s = bus.HSELS & is_active_trans(bus.HTRANSS) & bus.HREADYS;
  assign fwd_req_s   = trans_req_s & ~unmapped_req_s;
  assign capture_s   = fwd_req_s & ~bus.active_ip & ~reg_hold_r;
  assign release_s   = reg_hold_r & bus.active_ip & bus.readyout_ip;
  assign accept_s    = release_s | (fwd_req_s & bus.active_ip & ~reg_hold_r);

`ifdef RISCV_CORE_AHB_UNMAPPED_ERR_EN
  err_state_t err_state_r;

  assign unmapped_req_s = trans_req_s & bus.unmapped_ip;

  // two-cycle ERROR response for accesses that decode to no output stage
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_state_r <= ERR_IDLE;
    end else begin
      case (err_state_r)
        ERR_IDLE: err_state_r <= unmapped_req_s ? ERR_ONE : ERR_IDLE;
        ERR_ONE:  err_state_r <= ERR_TWO;
        ERR_TWO:  err_state_r <= unmapped_req_s ? ERR_ONE : ERR_IDLE;
        default:  err_state_r <= ERR_IDLE;
      endcase
    end
  end

  assign err_busy_s  = (err_state_r != ERR_IDLE);
  assign err_ready_s = (err_state_r == ERR_TWO);
`else
  logic unused_s;

  assign unused_s       = bus.unmapped_ip;
  assign unmapped_req_s = 1'b0;
  assign err_busy_s     = 1'b0;
  assign err_ready_s    = 1'b0;
`endif

  // pending-hold flag and data-phase ownership
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      reg_hold_r <= 1'b0;
      dphase_r   <= 1'b0;
    end else begin
      if (capture_s) begin
        reg_hold_r <= 1'b1;
      end else if (release_s) begin
        reg_hold_r <= 1'b0;
      end else begin
        reg_hold_r <= reg_hold_r;
      end
      if (accept_s) begin
        dphase_r <= 1'b1;
      end else if (hreadyout_s) begin
        dphase_r <= 1'b0;
      end else begin
        dphase_r <= dphase_r;
      end
    end
  end

  riscv_core_ahb_hold_reg #(
    .ctrl_t (ctrl_t)
  ) u_hold_reg (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .capture (capture_s),
    .hold    (reg_hold_r),
    .live    (live_s),
    .muxed   (muxed_s)
  );

  // response priority: local error, pending hold, granted data phase, idle
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = HRESP_OKAY;
    if (err_busy_s) begin
      hreadyout_s = err_ready_s;
      hresp_s     = HRESP_ERROR;
    end else if (reg_hold_r) begin
      hreadyout_s = 1'b0;
      hresp_s     = HRESP_OKAY;
    end else if (dphase_r) begin
      hreadyout_s = bus.readyout_ip;
      hresp_s     = bus.resp_ip;
    end else begin
      hreadyout_s = 1'b1;
      hresp_s     = HRESP_OKAY;
    end
  end

  assign bus.HREADYOUTS   = hreadyout_s;
  assign bus.HRESPS       = hresp_s;
  assign bus.sel_ip       = muxed_s.sel & ~(unmapped_req_s & ~reg_hold_r);
  assign bus.addr_ip      = muxed_s.addr;
  assign bus.auser_ip     = muxed_s.auser;
  assign bus.trans_ip     = muxed_s.trans;
  assign bus.write_ip     = muxed_s.write;
  assign bus.size_ip      = muxed_s.size;
  assign bus.burst_ip     = muxed_s.burst;
  assign bus.prot_ip      = muxed_s.prot;
  assign bus.master_ip    = muxed_s.master;
  assign bus.mastlock_ip  = muxed_s.mastlock;
  assign bus.held_tran_ip = reg_hold_r | (bus.HSELS & is_active_trans(bus.HTRANSS));

endmodule

// File: tb/tb_riscv_core_ahb_input_stage.sv
// Scoreboard bench for riscv_core_ahb_input_stage: directed scenarios followed
// by random traffic, checked against a transaction-level reference model.
module tb_riscv_core_ahb_input_stage;
  import riscv_core_ahb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int MST_W  = 4;

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [31:0] auser;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        lock;
    logic        active;
    logic        rdy;
    logic        resp;
    logic        unm;
  } stim_t;

  typedef struct {
    logic [1:0]  rr;
    logic        held;
    logic [82:0] fields;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  riscv_core_ahb_input_stage_if #(.ADDR_W(ADDR_W), .MST_W(MST_W)) bus ();

  riscv_core_ahb_input_stage #(.ADDR_W(ADDR_W), .MST_W(MST_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int    checks = 0;
  int    failures = 0;
  stim_t cur;
  logic  cur_rdy;
  stim_t pend_q[$];
  logic [1:0] err_q[$];
  bit    in_dp;
  exp_t  exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit unm_of(input stim_t s);
`ifdef RISCV_CORE_AHB_UNMAPPED_ERR_EN
    return s.unm;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [82:0] pack_fields(input stim_t s, input logic sel_v);
    return {sel_v, s.addr, s.auser, s.trans, s.write, s.size, s.burst, s.prot, s.master, s.lock};
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sel    = ($urandom_range(0, 9) < 8);
    s.trans  = 2'($urandom_range(0, 3));
    s.addr   = $urandom;
    s.auser  = $urandom;
    s.write  = 1'($urandom_range(0, 1));
    s.size   = 3'($urandom_range(0, 7));
    s.burst  = 3'($urandom_range(0, 7));
    s.prot   = 4'($urandom_range(0, 15));
    s.master = 4'($urandom_range(0, 15));
    s.lock   = ($urandom_range(0, 3) == 0);
    s.active = 1'($urandom_range(0, 1));
    s.rdy    = ($urandom_range(0, 9) < 7);
    s.resp   = ($urandom_range(0, 4) == 0);
    s.unm    = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  task automatic drive_bus(input stim_t s);
    bus.HSELS       = s.sel;
    bus.HTRANSS     = s.trans;
    bus.HADDRS      = s.addr;
    bus.HAUSERS     = s.auser;
    bus.HWRITES     = s.write;
    bus.HSIZES      = s.size;
    bus.HBURSTS     = s.burst;
    bus.HPROTS      = s.prot;
    bus.HMASTERS    = s.master;
    bus.HMASTLOCKS  = s.lock;
    bus.active_ip   = s.active;
    bus.readyout_ip = s.rdy;
    bus.resp_ip     = s.resp;
    bus.unmapped_ip = s.unm;
  endtask

  // Advance the reference model across a clock edge using last cycle's inputs.
  task automatic model_edge();
    bit req;
    bit acc;
    req = cur.sel && cur.trans[1] && cur_rdy;
    acc = 1'b0;
    if (err_q.size() > 0) void'(err_q.pop_front());
    if (pend_q.size() > 0) begin
      if (cur.active && cur.rdy) begin
        void'(pend_q.pop_front());
        acc = 1'b1;
      end
    end else if (req) begin
      if (unm_of(cur)) begin
        err_q.push_back(2'b01);
        err_q.push_back(2'b11);
      end else if (cur.active) begin
        acc = 1'b1;
      end else begin
        pend_q.push_back(cur);
      end
    end
    if (acc) in_dp = 1'b1;
    else if (cur_rdy) in_dp = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the response the model predicts for it.
  task automatic drive_and_expect(input stim_t s);
    exp_t e;
    logic [1:0] rr;
    bit req;
    drive_bus(s);
    if (err_q.size() > 0) rr = err_q[0];
    else if (pend_q.size() > 0) rr = 2'b00;
    else if (in_dp) rr = {s.rdy, s.resp};
    else rr = 2'b10;
    bus.HREADYS = rr[1];
    req = s.sel && s.trans[1] && rr[1];
    if (pend_q.size() > 0) e.fields = pack_fields(pend_q[0], 1'b1);
    else e.fields = pack_fields(s, s.sel && !(req && unm_of(s)));
    e.held = (pend_q.size() > 0) || (s.sel && s.trans[1]);
    e.rr = rr;
    exp_q.push_back(e);
    cur = s;
    cur_rdy = rr[1];
  endtask

  task automatic step(input stim_t s);
    @(posedge HCLK);
    model_edge();
    #1;
    drive_and_expect(s);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hreadyout"}, 128'(bus.HREADYOUTS), 128'(1'b1));
    chk({tag, "_hresp"}, 128'(bus.HRESPS), 128'(1'b0));
    chk({tag, "_held_tran"}, 128'(bus.held_tran_ip), 128'(1'b0));
    chk({tag, "_sel"}, 128'(bus.sel_ip), 128'(1'b0));
  endtask

  task automatic model_clear();
    pend_q.delete();
    err_q.delete();
    in_dp = 1'b0;
    cur = '0;
    cur_rdy = 1'b1;
  endtask

  // Monitor: compare DUT outputs with the oldest prediction, mid-cycle.
  initial begin
    forever begin
      @(negedge HCLK);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ready_resp", 128'({bus.HREADYOUTS, bus.HRESPS}), 128'(e.rr));
        chk("held_tran", 128'(bus.held_tran_ip), 128'(e.held));
        chk("fwd_fields", 128'({bus.sel_ip, bus.addr_ip, bus.auser_ip, bus.trans_ip, bus.write_ip,
                                bus.size_ip, bus.burst_ip, bus.prot_ip, bus.master_ip,
                                bus.mastlock_ip}), 128'(e.fields));
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    drive_bus(s);
    bus.HREADYS = 1'b1;
    model_clear();
    #12;
    check_reset_vals("reset_state");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // zero-latency pass-through write, then its data phase
    s = '0; s.sel = 1'b1; s.trans = HTRANS_NONSEQ; s.addr = 32'h2000_0010; s.write = 1'b1;
    s.active = 1'b1; s.rdy = 1'b1;
    step(s);
    s = '0; s.active = 1'b1; s.rdy = 1'b1;
    step(s);

    // held read while the master moves its address bus
    s = '0; s.sel = 1'b1; s.trans = HTRANS_NONSEQ; s.addr = 32'h0000_0100; s.size = 3'd2;
    step(s);
    for (int i = 0; i < 2; i++) begin
      s.addr = $urandom;
      step(s);
    end
    s.active = 1'b1; s.rdy = 1'b1;
    step(s);
    s = '0; s.active = 1'b1; s.rdy = 1'b1;
    step(s);

    // stalled data phase returning ERROR
    s = '0; s.sel = 1'b1; s.trans = HTRANS_NONSEQ; s.addr = 32'h0000_0300; s.active = 1'b1;
    s.rdy = 1'b1;
    step(s);
    s = '0; s.rdy = 1'b0; s.resp = 1'b1;
    step(s);
    step(s);
    s.rdy = 1'b1;
    step(s);
    s = '0; s.rdy = 1'b1;
    step(s);

    // locked burst beat held across arbitration delay
    s = '0; s.sel = 1'b1; s.trans = HTRANS_SEQ; s.addr = 32'h0000_0400; s.burst = 3'd1;
    s.lock = 1'b1;
    step(s);
    s.lock = 1'b0;
    step(s);
    step(s);
    s.active = 1'b1; s.rdy = 1'b1;
    step(s);
    s = '0; s.rdy = 1'b1;
    step(s);

    // unmapped access
    s = '0; s.sel = 1'b1; s.trans = HTRANS_SEQ; s.addr = 32'hF000_0000; s.unm = 1'b1;
    s.active = 1'b1; s.rdy = 1'b1;
    step(s);
    s = '0; s.active = 1'b1; s.rdy = 1'b1;
    step(s);
    step(s);
    step(s);

    // reset asserted while a transfer is held
    s = '0; s.sel = 1'b1; s.trans = HTRANS_NONSEQ; s.addr = 32'h0000_0500; s.lock = 1'b1;
    step(s);
    step(s);
    @(posedge HCLK);
    #3;
    s = '0;
    drive_bus(s);
    bus.HREADYS = 1'b1;
    HRESETn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    model_clear();
    s = '0;
    step(s);

    for (int i = 0; i < 3000; i++) begin
      step(rand_stim());
    end
    s = '0; s.rdy = 1'b1; s.active = 1'b1;
    for (int i = 0; i < 4; i++) step(s);
    @(negedge HCLK);
    #1;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
